vc32_bus_arbiter: RTL and testbench
===================================

Name: vc32_bus_arbiter

Overview:
- Two-master arbiter for the single external 16-bit memory bus sequencer in the vc32 top level.
- Master 0 is the CPU. Master 1 is a secondary requester, for example a DMA engine or debug loader.
- Both masters and the slave side use the same split read/write request interface: rreq byte-lane request, wmask byte-lane write mask, level requests held until a one-cycle done pulse.
- The block grants the bus round-robin, holds the grant for exactly one transaction, and inserts a one-cycle release gap so the sequencer returns to idle before the next request.

Parameters:
- DW, 16, data width in bits; lane count is DW/8 = 2.
- AW, 15, word-address width (address bits [15:1]).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- m0_rreq  input  2  master 0 read byte-lane request.
- m0_raddr  input  AW  master 0 read word address.
- m0_rdata  output  DW  master 0 read data.
- m0_rdone  output  1  master 0 read done pulse.
- m0_wmask  input  2  master 0 write byte mask.
- m0_waddr  input  AW  master 0 write word address.
- m0_wdata  input  DW  master 0 write data.
- m0_wdone  output  1  master 0 write done pulse.
- m1_*  same set and meanings as m0_*, for master 1.
- s_rreq  output  2  read request to sequencer.
- s_raddr  output  AW  read address to sequencer.
- s_rdata  input  DW  read data from sequencer.
- s_rdone  input  1  read done from sequencer.
- s_wmask  output  2  write mask to sequencer.
- s_waddr  output  AW  write address to sequencer.
- s_wdata  output  DW  write data to sequencer.
- s_wdone  input  1  write done from sequencer.
- busy  output  1  a grant is active (state GNT0 or GNT1).
- owner  output  1  index of the last-granted master.

Behaviour:
- Terminology:
  - A master "requests" when |mX_rreq or |mX_wmask is set.
  - Masters hold all request signals stable until the cycle after their done pulse, then may drop or change them.
- State machine (registered): IDLE, GNT0, GNT1, REL.
- Reset values:
  - state=IDLE, last=1 (so master 0 wins the first tie), busy=0, owner=1.
  - All s_* request outputs 0; all mX_rdone and mX_wdone 0.
- IDLE:
  - Only m0 requests -> GNT0.
  - Only m1 requests -> GNT1.
  - Both request -> grant the master != last.
  - Neither requests -> stay in IDLE.
  - On entry to GNTx, last <= x.
- GNTx:
  - s_rreq, s_raddr, s_wmask, s_waddr, s_wdata are driven combinationally from master x.
  - The other master sees no done pulses and is stalled.
  - A mixed request (rreq and wmask both nonzero) is forwarded unchanged; the sequencer serves the write first.
  - s_rdone or s_wdone asserted -> forward the pulse combinationally to mX_rdone or mX_wdone in the same cycle, then next state = REL.
- REL:
  - Exactly one cycle with all s_* requests forced to 0.
  - Done pulses are not forwarded.
  - Next state = IDLE.
- Outside GNTx:
  - s_rreq=0 and s_wmask=0.
  - s_raddr, s_waddr, s_wdata are driven from master 0 (don't care to the sequencer, but must be deterministic).
- Read data:
  - m0_rdata and m1_rdata both equal s_rdata combinationally.
  - Only the granted master's rdone qualifies the data.
- Done pulses:
  - A done pulse arriving in IDLE or REL is a protocol error and is dropped.
  - The state does not change.
- Latency:
  - Request first seen in IDLE at cycle N -> s_* request driven from cycle N+1.
  - Done at cycle M -> REL at M+1, IDLE at M+2.
  - Earliest next grant is visible at M+3.
- Fairness:
  - With both masters requesting continuously, grants strictly alternate 0,1,0,1...
  - Worst-case wait is one foreign transaction plus its REL cycle.
- Reset mid-transaction:
  - Everything returns to reset values in the next cycle.
  - Any in-flight done is not forwarded.
  - The sequencer shares the same reset.
- busy=1 in GNT0 and GNT1. owner=last.

Test Plan:
- Reset, then m0 write wmask=2'b11, waddr=15'h1234, wdata=16'hBEEF.
  - Required: s_wmask=2'b11 from the next cycle; s_waddr=15'h1234.
  - s_wdone pulse -> one-cycle m0_wdone, m1_wdone=0, then one REL cycle with s_wmask=0.
- m0 and m1 both read from IDLE after reset.
  - Required: m0 granted first, m1 granted after m0's rdone plus the REL cycle.
  - Repeat both requests continuously -> grants alternate 0,1,0,1 over 4 transactions.
- m1 read rreq=2'b01 with s_rdata=16'h00A5.
  - Required: m1_rdone pulses with m1_rdata=16'h00A5; m0_rdone stays 0.
- m0 issues rreq=2'b11 and wmask=2'b01 together.
  - Required: both forwarded unchanged.
  - Transaction ends on the first done pulse; the next grant follows after REL.
- Assert reset during GNT1 (the cycle before s_wdone).
  - Required: next cycle s_wmask=0, busy=0, owner=1, and no m1_wdone.
  - First grant after reset goes to m0 when both request.
- Inject s_rdone while in IDLE.
  - Required: no mX_rdone pulse, state remains IDLE.

Source files
------------

// File: rtl/vc32_bus_arbiter.sv
// Two-master round-robin arbiter in front of the vc32 external 16-bit memory sequencer.
// Each grant covers exactly one transaction and is followed by a one-cycle release gap.
module vc32_bus_arbiter #(
  parameter int DW = 16,
  parameter int AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW/8-1:0]   m0_rreq,
  input  logic [AW-1:0]     m0_raddr,
  output logic [DW-1:0]     m0_rdata,
  output logic              m0_rdone,
  input  logic [DW/8-1:0]   m0_wmask,
  input  logic [AW-1:0]     m0_waddr,
  input  logic [DW-1:0]     m0_wdata,
  output logic              m0_wdone,
  input  logic [DW/8-1:0]   m1_rreq,
  input  logic [AW-1:0]     m1_raddr,
  output logic [DW-1:0]     m1_rdata,
  output logic              m1_rdone,
  input  logic [DW/8-1:0]   m1_wmask,
  input  logic [AW-1:0]     m1_waddr,
  input  logic [DW-1:0]     m1_wdata,
  output logic              m1_wdone,
  output logic [DW/8-1:0]   s_rreq,
  output logic [AW-1:0]     s_raddr,
  input  logic [DW-1:0]     s_rdata,
  input  logic              s_rdone,
  output logic [DW/8-1:0]   s_wmask,
  output logic [AW-1:0]     s_waddr,
  output logic [DW-1:0]     s_wdata,
  input  logic              s_wdone,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, REL} state_t;

  state_t r_state, w_next;
  logic   r_last;
  logic   w_req0, w_req1;

  assign w_req0 = (|m0_rreq) | (|m0_wmask);
  assign w_req1 = (|m1_rreq) | (|m1_wmask);

  // r_last tracks the master granted on IDLE exit; reset to 1 so m0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == GNT0) r_last <= 1'b0;
      if (r_state == IDLE && w_next == GNT1) r_last <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && (!w_req1 || r_last)) w_next = GNT0;
        else if (w_req1)                   w_next = GNT1;
      end
      GNT0, GNT1: if (s_rdone || s_wdone) w_next = REL;
      REL:        w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Outside a grant, addresses/data follow m0 so the bus stays deterministic
  always_comb begin
    s_rreq   = '0;
    s_wmask  = '0;
    s_raddr  = m0_raddr;
    s_waddr  = m0_waddr;
    s_wdata  = m0_wdata;
    m0_rdone = 1'b0;
    m0_wdone = 1'b0;
    m1_rdone = 1'b0;
    m1_wdone = 1'b0;
    case (r_state)
      GNT0: begin
        s_rreq   = m0_rreq;
        s_wmask  = m0_wmask;
        m0_rdone = s_rdone;
        m0_wdone = s_wdone;
      end
      GNT1: begin
        s_rreq   = m1_rreq;
        s_raddr  = m1_raddr;
        s_wmask  = m1_wmask;
        s_waddr  = m1_waddr;
        s_wdata  = m1_wdata;
        m1_rdone = s_rdone;
        m1_wdone = s_wdone;
      end
      default: ;
    endcase
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign busy     = (r_state == GNT0) || (r_state == GNT1);
  assign owner    = r_last;

endmodule

// File: tb/tb_vc32_bus_arbiter.sv
// Cycle-by-cycle vector table for vc32_bus_arbiter plus a short hand-written grant sequence.
module tb_vc32_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m0_rreq, m0_wmask, m1_rreq, m1_wmask;
  logic [14:0] m0_raddr, m0_waddr, m1_raddr, m1_waddr;
  logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_rdata;
  logic        m0_rdone, m0_wdone, m1_rdone, m1_wdone;
  logic [1:0]  s_rreq, s_wmask;
  logic [14:0] s_raddr, s_waddr;
  logic [15:0] s_wdata;
  logic        s_rdone, s_wdone, busy, owner;

  int n_chk = 0;
  int n_fail = 0;

  vc32_bus_arbiter #(.DW(16), .AW(15)) dut (
    .clk(clk), .reset(reset),
    .m0_rreq(m0_rreq), .m0_raddr(m0_raddr), .m0_rdata(m0_rdata), .m0_rdone(m0_rdone),
    .m0_wmask(m0_wmask), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wdone(m0_wdone),
    .m1_rreq(m1_rreq), .m1_raddr(m1_raddr), .m1_rdata(m1_rdata), .m1_rdone(m1_rdone),
    .m1_wmask(m1_wmask), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wdone(m1_wdone),
    .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rdone(s_rdone),
    .s_wmask(s_wmask), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wdone(s_wdone),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs held for the cycle, expected outputs sampled mid-cycle
  typedef struct {
    logic       rst;
    logic [1:0] m0r, m0w, m1r, m1w;
    logic       sr, sw;
    logic [1:0] er, ew;
    logic       esel;
    logic [3:0] edone;   // {m1_wdone, m1_rdone, m0_wdone, m0_rdone}
    logic       ebusy, eown;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic [1:0] m0r, m0w, m1r, m1w,
                     input logic sr, sw, input logic [1:0] er, ew, input logic esel,
                     input logic [3:0] edone, input logic ebusy, eown);
    vec_t v;
    v.rst = rst; v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w;
    v.sr = sr; v.sw = sw; v.er = er; v.ew = ew; v.esel = esel;
    v.edone = edone; v.ebusy = ebusy; v.eown = eown;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    logic [15:0] rd;
    bit seen;

    // rst m0r m0w m1r m1w sr sw | er ew sel done busy own
    add(0, 0,0,0,0, 0,0, 0,0,0,4'b0000, 0,1);  // 0  reset state
    add(0, 0,3,0,0, 0,0, 0,0,0,4'b0000, 0,1);  // 1  m0 write seen in IDLE
    add(0, 0,3,0,0, 0,0, 0,3,0,4'b0000, 1,0);  // 2  GNT0
    add(0, 0,3,0,0, 0,1, 0,3,0,4'b0010, 1,0);  // 3  wdone forwarded
    add(0, 0,3,0,0, 0,0, 0,0,0,4'b0000, 0,0);  // 4  REL forces 0
    add(1, 0,0,0,0, 0,0, 0,0,0,4'b0000, 0,0);  // 5  reset asserted
    add(0, 3,0,3,0, 0,0, 0,0,0,4'b0000, 0,1);  // 6  both read
    add(0, 3,0,3,0, 0,0, 3,0,0,4'b0000, 1,0);  // 7  m0 first
    add(0, 3,0,3,0, 1,0, 3,0,0,4'b0001, 1,0);  // 8
    add(0, 3,0,3,0, 0,0, 0,0,0,4'b0000, 0,0);  // 9  REL
    add(0, 3,0,3,0, 0,0, 0,0,0,4'b0000, 0,0);  // 10 IDLE
    add(0, 3,0,3,0, 0,0, 3,0,1,4'b0000, 1,1);  // 11 m1
    add(0, 3,0,3,0, 1,0, 3,0,1,4'b0100, 1,1);  // 12
    add(0, 3,0,3,0, 0,0, 0,0,0,4'b0000, 0,1);  // 13 REL
    add(0, 3,0,3,0, 0,0, 0,0,0,4'b0000, 0,1);  // 14 IDLE
    add(0, 3,0,3,0, 1,0, 3,0,0,4'b0001, 1,0);  // 15 m0 again
    add(0, 3,0,3,0, 0,0, 0,0,0,4'b0000, 0,0);  // 16 REL
    add(0, 3,0,3,0, 0,0, 0,0,0,4'b0000, 0,0);  // 17 IDLE
    add(0, 3,0,3,0, 1,0, 3,0,1,4'b0100, 1,1);  // 18 m1 again
    add(0, 0,0,1,0, 1,0, 0,0,0,4'b0000, 0,1);  // 19 REL, stray rdone dropped
    add(0, 0,0,1,0, 0,0, 0,0,0,4'b0000, 0,1);  // 20 m1 single-lane read
    add(0, 0,0,1,0, 0,0, 1,0,1,4'b0000, 1,1);  // 21
    add(0, 0,0,1,0, 1,0, 1,0,1,4'b0100, 1,1);  // 22 rdata 00A5
    add(0, 0,0,0,0, 0,0, 0,0,0,4'b0000, 0,1);  // 23 REL
    add(0, 3,1,0,0, 0,0, 0,0,0,4'b0000, 0,1);  // 24 m0 mixed
    add(0, 3,1,0,0, 0,0, 3,1,0,4'b0000, 1,0);  // 25 both forwarded
    add(0, 3,1,0,0, 0,1, 3,1,0,4'b0010, 1,0);  // 26 first done ends it
    add(0, 3,1,0,0, 0,0, 0,0,0,4'b0000, 0,0);  // 27 REL
    add(0, 3,1,0,0, 0,0, 0,0,0,4'b0000, 0,0);  // 28 IDLE
    add(0, 3,1,0,0, 1,0, 3,1,0,4'b0001, 1,0);  // 29 next grant
    add(0, 0,0,0,0, 0,0, 0,0,0,4'b0000, 0,0);  // 30 REL
    add(0, 0,0,0,3, 0,0, 0,0,0,4'b0000, 0,0);  // 31 m1 write
    add(0, 0,0,0,3, 0,0, 0,3,1,4'b0000, 1,1);  // 32 GNT1
    add(1, 0,0,0,3, 0,0, 0,3,1,4'b0000, 1,1);  // 33 reset in GNT1
    add(0, 1,0,0,3, 0,1, 0,0,0,4'b0000, 0,1);  // 34 in-flight wdone dropped
    add(0, 1,0,0,3, 0,0, 1,0,0,4'b0000, 1,0);  // 35 m0 wins after reset
    add(0, 1,0,0,3, 1,0, 1,0,0,4'b0001, 1,0);  // 36
    add(0, 0,0,0,0, 0,0, 0,0,0,4'b0000, 0,0);  // 37 REL
    add(0, 0,0,0,0, 1,1, 0,0,0,4'b0000, 0,0);  // 38 done in IDLE
    add(0, 0,0,0,0, 0,0, 0,0,0,4'b0000, 0,0);  // 39 still IDLE

    m0_raddr = 15'h0100; m0_waddr = 15'h1234; m0_wdata = 16'hBEEF;
    m1_raddr = 15'h0200; m1_waddr = 15'h0300; m1_wdata = 16'hCAFE;
    m0_rreq = '0; m0_wmask = '0; m1_rreq = '0; m1_wmask = '0;
    s_rdone = 0; s_wdone = 0; s_rdata = '0;
    reset = 1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      #1;
      reset = tv[i].rst;
      m0_rreq = tv[i].m0r; m0_wmask = tv[i].m0w;
      m1_rreq = tv[i].m1r; m1_wmask = tv[i].m1w;
      s_rdone = tv[i].sr;  s_wdone = tv[i].sw;
      rd = tv[i].sr ? 16'h00A5 : (16'h5A00 ^ 16'(i));
      s_rdata = rd;
      @(negedge clk);
      chk($sformatf("v%0d s_rreq", i), 32'(s_rreq), 32'(tv[i].er));
      chk($sformatf("v%0d s_wmask", i), 32'(s_wmask), 32'(tv[i].ew));
      chk($sformatf("v%0d s_raddr", i), 32'(s_raddr), tv[i].esel ? 32'h0200 : 32'h0100);
      chk($sformatf("v%0d s_waddr", i), 32'(s_waddr), tv[i].esel ? 32'h0300 : 32'h1234);
      chk($sformatf("v%0d s_wdata", i), 32'(s_wdata), tv[i].esel ? 32'hCAFE : 32'hBEEF);
      chk($sformatf("v%0d dones", i), 32'({m1_wdone, m1_rdone, m0_wdone, m0_rdone}), 32'(tv[i].edone));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].ebusy));
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(tv[i].eown));
      chk($sformatf("v%0d m0_rdata", i), 32'(m0_rdata), 32'(rd));
      chk($sformatf("v%0d m1_rdata", i), 32'(m1_rdata), 32'(rd));
      @(posedge clk);
    end

    // Hand sequence: lone m1 write, bounded wait for the grant, then complete it
    #1;
    s_rdone = 0; s_wdone = 0;
    m1_wmask = 2'b01;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("hand grant seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("hand owner", 32'(owner), 32'd1);
      chk("hand s_wmask", 32'(s_wmask), 32'h1);
      chk("hand s_waddr", 32'(s_waddr), 32'h0300);
      @(posedge clk); #1;
      s_wdone = 1;
      @(negedge clk);
      chk("hand m1_wdone", 32'(m1_wdone), 32'd1);
      chk("hand m0_wdone", 32'(m0_wdone), 32'd0);
      @(posedge clk); #1;
      s_wdone = 0;
      m1_wmask = '0;
      @(negedge clk);
      chk("hand REL busy", 32'(busy), 32'd0);
      chk("hand REL s_wmask", 32'(s_wmask), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
